// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two message requesters, the arbiter and the UART send buffer.
// The arbiter connects through the slave modport; the master modport is the requester/sink side.
interface uart_tx_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_data;
  logic        req0_id;
  logic        req0_last;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_data;
  logic        req1_id;
  logic        req1_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_id;

  modport master (
    output req0_valid, req0_data, req0_id, req0_last,
    output req1_valid, req1_data, req1_id, req1_last,
    output out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_id, req0_last,
    input  req1_valid, req1_data, req1_id, req1_last,
    input  out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester message arbiter for the UART send buffer: per-requester FIFOs,
// round-robin between messages, never interleaving words of different messages.
module uart_tx_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  uart_tx_arbiter_if.slave   bus,
  output logic [1:0]         owner
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  // FIFO entry layout: {last, id, data}
  logic [33:0]   mem_q  [2][DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] rptr_q [2];
  logic [CW-1:0] cnt_q  [2];
  logic [CW-1:0] cnt_d  [2];
  logic [33:0]   wdata  [2];
  logic [33:0]   head   [2];
  logic [1:0]    ready_q;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    nempty;

  logic [1:0]    state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic          sel;
  logic          slot_free;
  logic          out_valid_q;
  logic [31:0]   out_data_q;
  logic          out_id_q;

  assign wdata[0] = {bus.req0_last, bus.req0_id, bus.req0_data};
  assign wdata[1] = {bus.req1_last, bus.req1_id, bus.req1_data};
  assign push     = {bus.req1_valid & ready_q[1], bus.req0_valid & ready_q[0]};
  assign head[0]  = mem_q[0][rptr_q[0]];
  assign head[1]  = mem_q[1][rptr_q[1]];
  assign nempty   = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign slot_free = !out_valid_q || bus.out_ready;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      cnt_d[n] = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
    end
  end

  // Arbitration: a granted requester keeps the slot until its last word is popped.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    pop          = 2'b00;
    sel          = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_free && nempty != 2'b00) begin
          sel      = (nempty == 2'b11) ? ~last_owner_q : nempty[1];
          pop[sel] = 1'b1;
          if (head[sel][33]) begin
            last_owner_d = sel;
          end else begin
            state_d = sel ? GRANT1 : GRANT0;
          end
        end
      end
      GRANT0: begin
        sel = 1'b0;
        if (slot_free && nempty[0]) begin
          pop[0] = 1'b1;
          if (head[0][33]) begin
            state_d      = IDLE;
            last_owner_d = 1'b0;
          end
        end
      end
      GRANT1: begin
        sel = 1'b1;
        if (slot_free && nempty[1]) begin
          pop[1] = 1'b1;
          if (head[1][33]) begin
            state_d      = IDLE;
            last_owner_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_q[n][wptr_q[n]] <= wdata[n];
      end
    end
  end

  // Ready is registered from the next-cycle occupancy so a full FIFO never accepts.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int n = 0; n < 2; n++) begin
        wptr_q[n] <= '0;
        rptr_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
      ready_q <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wptr_q[n] <= wptr_q[n] + PW'(1);
        if (pop[n])  rptr_q[n] <= rptr_q[n] + PW'(1);
        cnt_q[n]   <= cnt_d[n];
        ready_q[n] <= (cnt_d[n] < CW'(DEPTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      if (pop != 2'b00) begin
        out_valid_q <= 1'b1;
        out_data_q  <= head[sel][31:0];
        out_id_q    <= head[sel][32];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = ready_q[0];
  assign bus.req1_ready = ready_q[1];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_id     = out_id_q;
  assign owner          = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a per-cycle vector table followed by
// hand-written multi-cycle sequences for gaps, back-pressure and mid-message reset.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] owner;
  int         tests = 0;
  int         fails = 0;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.DEPTH(4)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus),
    .owner (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic        v0;
    logic [31:0] d0;
    logic        id0;
    logic        l0;
    logic        v1;
    logic [31:0] d1;
    logic        id1;
    logic        l1;
    logic        er0;
    logic        er1;
    logic        eov;
    logic [31:0] eod;
    logic        eoid;
    logic [1:0]  eown;
  } vec_t;

  vec_t          vecs[$];
  logic [31:0]   expQ[$];
  logic [31:0]   expWord;
  logic [31:0]   prevData;
  logic          stallPrev;
  logic          acc0, acc1;
  int            idx0, idx1, r1Seen;

  function automatic vec_t mk(input logic rs, input logic v0, input logic [31:0] d0,
                              input logic id0, input logic l0, input logic v1,
                              input logic [31:0] d1, input logic id1, input logic l1,
                              input logic er0, input logic er1, input logic eov,
                              input logic [31:0] eod, input logic eoid, input logic [1:0] eown);
    vec_t v;
    v.rstn = rs; v.v0 = v0; v.d0 = d0; v.id0 = id0; v.l0 = l0;
    v.v1 = v1; v.d1 = d1; v.id1 = id1; v.l1 = l1;
    v.er0 = er0; v.er1 = er1; v.eov = eov; v.eod = eod; v.eoid = eoid; v.eown = eown;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstn           = v.rstn;
    bus.req0_valid = v.v0;
    bus.req0_data  = v.d0;
    bus.req0_id    = v.id0;
    bus.req0_last  = v.l0;
    bus.req1_valid = v.v1;
    bus.req1_data  = v.d1;
    bus.req1_id    = v.id1;
    bus.req1_last  = v.l1;
    bus.out_ready  = 1'b1;
  endtask

  task automatic idleInputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_last  = 1'b0;
    bus.req1_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn           = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_id = 1'b0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_id = 1'b0; bus.req1_last = 1'b0;
    bus.out_ready  = 1'b1;

    // Each row: inputs driven before an edge, outputs expected right after it.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h41424344, 0, 1, 0, 0, 0, 0,  1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 32'h41424344, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h41424344, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 1, 32'hA0000001, 1, 1, 1, 32'hB0000001, 0, 1,  1, 1, 0, 32'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 32'hA0000001, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 32'hB0000001, 0, 0));
    vecs.push_back(mk(1, 1, 32'hA0000002, 0, 1, 1, 32'hB0000002, 1, 1,  1, 1, 0, 32'hB0000001, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 32'hA0000002, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 32'hB0000002, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'hB0000002, 1, 0));
    vecs.push_back(mk(1, 1, 32'hC0DE0001, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'hB0000002, 1, 0));
    vecs.push_back(mk(1, 1, 32'hC0DE0002, 0, 0, 0, 0, 0, 0,  1, 1, 1, 32'hC0DE0001, 0, 1));
    vecs.push_back(mk(1, 1, 32'hC0DE0003, 1, 1, 0, 0, 0, 0,  1, 1, 1, 32'hC0DE0002, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 32'hC0DE0003, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 32'hC0DE0003, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d.req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].er0));
      checkOutput($sformatf("v%0d.req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].er1));
      checkOutput($sformatf("v%0d.out_valid", i),  32'(bus.out_valid),  32'(vecs[i].eov));
      checkOutput($sformatf("v%0d.out_data", i),   bus.out_data,        vecs[i].eod);
      checkOutput($sformatf("v%0d.out_id", i),     32'(bus.out_id),     32'(vecs[i].eoid));
      checkOutput($sformatf("v%0d.owner", i),      32'(owner),          32'(vecs[i].eown));
    end
    idleInputs();

    // req1 message with a 4-cycle gap before word 3, req0 streaming behind it.
    expQ.delete();
    for (int i = 1; i <= 3; i++) expQ.push_back(32'h11110000 + 32'(i));
    for (int i = 1; i <= 6; i++) expQ.push_back(32'h20000000 + 32'(i));
    idx0 = 0; idx1 = 0; r1Seen = 0;
    for (int cyc = 0; cyc < 100 && expQ.size() > 0; cyc++) begin
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        expWord = expQ.pop_front();
        checkOutput("s1.out_data", bus.out_data, expWord);
        if (expWord[31:28] == 4'h1) r1Seen++;
      end
      if (r1Seen == 1 || r1Seen == 2) checkOutput("s1.owner", 32'(owner), 32'd2);
      bus.req0_valid = (idx0 < 6);
      bus.req0_data  = 32'h20000001 + 32'(idx0);
      bus.req0_id    = 1'b0;
      bus.req0_last  = (idx0 == 5);
      bus.req1_valid = (idx1 < 2) || (idx1 == 2 && cyc >= 6);
      bus.req1_data  = 32'h11110001 + 32'(idx1);
      bus.req1_id    = 1'b0;
      bus.req1_last  = (idx1 == 2);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      tick();
      if (acc0) idx0++;
      if (acc1) idx1++;
    end
    checkOutput("s1.remaining", 32'(expQ.size()), 32'd0);
    idleInputs();
    tick();
    tick();

    // Back-pressure: five req0 words with out_ready low fill output reg plus FIFO.
    bus.out_ready = 1'b0;
    idx0 = 0;
    for (int cyc = 0; cyc < 20 && idx0 < 5; cyc++) begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'h50000001 + 32'(idx0);
      bus.req0_id    = idx0[0];
      bus.req0_last  = (idx0 == 4);
      acc0 = bus.req0_ready;
      tick();
      if (acc0) begin
        idx0++;
        checkOutput("s2.req0_ready", 32'(bus.req0_ready), 32'(idx0 < 5));
      end
    end
    checkOutput("s2.accepted", 32'(idx0), 32'd5);
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("s2.full_ready", 32'(bus.req0_ready), 32'd0);
      checkOutput("s2.hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("s2.hold_data", bus.out_data, 32'h50000001);
    end
    expQ.delete();
    for (int i = 1; i <= 5; i++) expQ.push_back(32'h50000000 + 32'(i));
    for (int cyc = 0; cyc < 20 && expQ.size() > 0; cyc++) begin
      bus.out_ready = 1'b1;
      if (bus.out_valid) checkOutput("s2.drain_data", bus.out_data, expQ.pop_front());
      tick();
    end
    checkOutput("s2.remaining", 32'(expQ.size()), 32'd0);
    checkOutput("s2.ready_back", 32'(bus.req0_ready), 32'd1);
    tick();

    // Toggling out_ready: stalled words must hold, none lost or repeated.
    expQ.delete();
    for (int i = 1; i <= 4; i++) expQ.push_back(32'h70000000 + 32'(i));
    idx1 = 0; stallPrev = 1'b0; prevData = '0;
    for (int cyc = 0; cyc < 60 && expQ.size() > 0; cyc++) begin
      if (stallPrev) begin
        checkOutput("s3.hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("s3.hold_data", bus.out_data, prevData);
      end
      bus.out_ready = (cyc % 2 == 0);
      if (bus.out_valid && bus.out_ready) checkOutput("s3.out_data", bus.out_data, expQ.pop_front());
      stallPrev = bus.out_valid && !bus.out_ready;
      prevData  = bus.out_data;
      bus.req1_valid = (idx1 < 4);
      bus.req1_data  = 32'h70000001 + 32'(idx1);
      bus.req1_id    = idx1[0];
      bus.req1_last  = (idx1 == 3);
      acc1 = bus.req1_valid && bus.req1_ready;
      tick();
      if (acc1) idx1++;
    end
    checkOutput("s3.remaining", 32'(expQ.size()), 32'd0);
    idleInputs();
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset in the middle of a req0 message discards everything buffered.
    for (int i = 0; i < 3; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_data  = 32'h90000001 + 32'(i);
      bus.req0_id    = 1'b0;
      bus.req0_last  = 1'b0;
      tick();
    end
    idleInputs();
    checkOutput("s4.pre_valid", 32'(bus.out_valid), 32'd1);
    rstn = 1'b0;
    tick();
    checkOutput("s4.rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("s4.rst_data", bus.out_data, 32'd0);
    checkOutput("s4.rst_ready", 32'(bus.req0_ready), 32'd0);
    checkOutput("s4.rst_owner", 32'(owner), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("s4.no_stale", 32'(bus.out_valid), 32'd0);
      checkOutput("s4.idle_owner", 32'(owner), 32'd0);
    end
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hA5A5A5A5;
    bus.req0_id    = 1'b1;
    bus.req0_last  = 1'b1;
    tick();
    idleInputs();
    checkOutput("s4.lat_k", 32'(bus.out_valid), 32'd0);
    tick();
    checkOutput("s4.lat_k1_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("s4.lat_k1_data", bus.out_data, 32'hA5A5A5A5);
    checkOutput("s4.lat_k1_id", 32'(bus.out_id), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
